// File: rtl/calc_disp_pkg.sv
// Shared constants for the calculator result display: active-low gfedcba segment codes,
// the conversion FSM state type and the BCD-digit to segment lookup.
package calc_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    function automatic logic [6:0] seg_of(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/calc_result_display_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock, RES_W steps per conversion.
// o_done is high during the cycle whose closing edge performs the final shift.
module bin2bcd_seq #(
    parameter int RES_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [RES_W-1:0] i_mag,
    output logic             o_busy,
    output logic             o_done,
    output logic [11:0]      o_bcd
);
    localparam int SR_W  = RES_W + 12;
    localparam int CNT_W = $clog2(RES_W + 1);

    logic [SR_W-1:0]  r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [SR_W-1:0]  w_adj;

    always_comb begin
        w_adj = r_sr;
        for (int k = 0; k < 3; k++) begin
            if (r_sr[RES_W+4*k +: 4] >= 4'd5)
                w_adj[RES_W+4*k +: 4] = r_sr[RES_W+4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_sr   <= {12'b0, i_mag};
            r_cnt  <= CNT_W'(RES_W);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_sr  <= {w_adj[SR_W-2:0], 1'b0};
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1))
                r_busy <= 1'b0;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == CNT_W'(1));
    assign o_bcd  = r_sr[SR_W-1:RES_W];

endmodule

// File: rtl/calc_result_display.sv
// Signed result to 4-digit multiplexed seven-segment display (sign + 3 BCD digits).
// Define LEADING_ZERO_BLANK_EN to blank leading zeros in the hundreds/tens positions.
module calc_result_display
    import calc_disp_pkg::*;
#(
    parameter int RES_W    = 9,
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             res_valid,
    input  logic [RES_W-1:0] result,
    output logic             busy,
    output logic             done,
    output logic [6:0]       seg,
    output logic [3:0]       an
);
    localparam int CNT_W = $clog2(SCAN_DIV);

    state_t           r_state;
    logic             r_neg;
    logic             r_busy;
    logic             r_done;
    logic [3:0][6:0]  r_disp;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]       r_scan_idx;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;

    logic             w_start;
    logic [RES_W-1:0] w_mag;
    logic             w_bcd_busy;
    logic             w_bcd_done;
    logic [11:0]      w_bcd;
    logic [6:0]       w_seg_h;
    logic [6:0]       w_seg_t;
    logic [6:0]       w_seg_o;

    assign w_start = (r_state == IDLE) && res_valid;
    // -256 negates to itself in RES_W bits, which read unsigned is the wanted 256
    assign w_mag   = result[RES_W-1] ? (~result + RES_W'(1)) : result;

    bin2bcd_seq #(.RES_W(RES_W)) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_mag   (w_mag),
        .o_busy  (w_bcd_busy),
        .o_done  (w_bcd_done),
        .o_bcd   (w_bcd)
    );

    always_comb begin
        w_seg_h = seg_of(w_bcd[11:8]);
        w_seg_t = seg_of(w_bcd[7:4]);
        w_seg_o = seg_of(w_bcd[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
        if (w_bcd[11:8] == 4'd0) begin
            w_seg_h = SEG_BLANK;
            if (w_bcd[7:4] == 4'd0)
                w_seg_t = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_disp  <= {4{SEG_BLANK}};
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= res_valid;
                    if (res_valid) begin
                        r_neg   <= result[RES_W-1];
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    if (w_bcd_done)
                        r_state <= UPDATE;
                end
                UPDATE: begin
                    r_disp  <= {(r_neg ? SEG_MINUS : SEG_BLANK), w_seg_h, w_seg_t, w_seg_o};
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Scanning is free-running so a conversion never disturbs the refresh rate
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_scan_idx <= 2'd0;
            r_seg      <= SEG_BLANK;
            r_an       <= 4'hF;
        end else begin
            if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_scan_idx <= r_scan_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_an  <= ~(4'b0001 << r_scan_idx);
            r_seg <= r_disp[r_scan_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && r_state == UPDATE)
            assert (w_bcd[11:8] <= 4'd9 && w_bcd[7:4] <= 4'd9 && w_bcd[3:0] <= 4'd9);
        if (!reset && r_state == CONV)
            assert (w_bcd_busy);
    end

    assign busy = r_busy;
    assign done = r_done;
    assign seg  = r_seg;
    assign an   = r_an;

endmodule

// File: tb/tb_calc_result_display.sv
// Directed plus randomized bench for calc_result_display; expected digits come from
// integer division of the result magnitude, expected scan slots from cycle arithmetic.
module tb_calc_result_display;
    localparam int RES_W = 9;
    localparam int LAT   = RES_W + 1;
    localparam logic [6:0] SEGS [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] MINUS = 7'h3F;
    localparam logic [6:0] BLANK = 7'h7F;

    logic             clk = 1'b0;
    logic             reset;
    logic             res_valid;
    logic [RES_W-1:0] result;
    logic             busy;
    logic             done;
    logic [6:0]       seg;
    logic [3:0]       an;

    int n_vec  = 0;
    int n_fail = 0;

    calc_result_display #(.RES_W(RES_W), .SCAN_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .res_valid (res_valid),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0][6:0] model(input logic [RES_W-1:0] r);
        logic [3:0][6:0] d;
        int v, mag, h, t, o;
        v   = r[RES_W-1] ? int'(r) - (1 << RES_W) : int'(r);
        mag = (v < 0) ? -v : v;
        h   = mag / 100;
        t   = (mag / 10) % 10;
        o   = mag % 10;
        d[3] = (v < 0) ? MINUS : BLANK;
        d[2] = SEGS[h];
        d[1] = SEGS[t];
        d[0] = SEGS[o];
`ifdef LEADING_ZERO_BLANK_EN
        if (h == 0) d[2] = BLANK;
        if (h == 0 && t == 0) d[1] = BLANK;
`endif
        return d;
    endfunction

    // Watch one full scan rotation; every active slot must show its expected digit
    task automatic scan_check(input string tag, input logic [3:0][6:0] exp);
        logic [3:0] mask;
        int slot;
        mask = '0;
        for (int c = 0; c < 16; c++) begin
            tick();
            case (an)
                4'b1110: slot = 0;
                4'b1101: slot = 1;
                4'b1011: slot = 2;
                4'b0111: slot = 3;
                default: slot = -1;
            endcase
            if (slot < 0) begin
                chk({tag, "_an"}, 32'(an), 32'hE);
            end else begin
                chk({tag, "_seg"}, 32'(seg), 32'(exp[slot]));
                mask[slot] = 1'b1;
            end
        end
        chk({tag, "_cover"}, 32'(mask), 32'hF);
    endtask

    task automatic run_result(input logic [RES_W-1:0] r);
        int lat;
        res_valid = 1'b1;
        result    = r;
        tick();
        res_valid = 1'b0;
        result    = $urandom_range(0, (1 << RES_W) - 1);
        chk("busy_accept", 32'(busy), 32'd1);
        lat = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (done) begin
                lat = c;
                break;
            end
        end
        chk("done_latency", 32'(lat), 32'(LAT));
        chk("busy_at_done", 32'(busy), 32'd1);
        tick();
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        scan_check("disp", model(r));
    endtask

    initial begin
        logic [RES_W-1:0] dir [8];
        int dones, first;

        reset     = 1'b1;
        res_valid = 1'b0;
        result    = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_seg",  32'(seg),  32'h7F);
        chk("rst_an",   32'(an),   32'hF);
        reset = 1'b0;

        // Exact scan timing from reset release: each slot held 4 cycles, blank digits
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("scan_an_seq", 32'(an), 32'(~(4'b0001 << (((k - 1) / 4) % 4)) & 4'hF));
            chk("scan_blank", 32'(seg), 32'(BLANK));
        end

        dir = '{9'h1FB, 9'h100, 9'h0FF, 9'h000, 9'h001, 9'h1FF, 9'h064, 9'h19C};
        foreach (dir[i]) run_result(dir[i]);

        // A second request during conversion must be dropped
        res_valid = 1'b1;
        result    = 9'h00C;
        tick();
        res_valid = 1'b0;
        dones = 0;
        first = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                res_valid = 1'b1;
                result    = 9'h007;
            end
            tick();
            if (c == 3) res_valid = 1'b0;
            if (done) begin
                dones++;
                if (first == 0) first = c;
            end
        end
        chk("ignore_done_count", 32'(dones), 32'd1);
        chk("ignore_done_lat", 32'(first), 32'(LAT));
        scan_check("ignore_disp", model(9'h00C));

        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            run_result(RES_W'($urandom_range(0, (1 << RES_W) - 1)));
        end

        // Reset during conversion: abandon, no done, display back to blank
        res_valid = 1'b1;
        result    = 9'h0B4;
        tick();
        res_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_seg",  32'(seg),  32'h7F);
        chk("midrst_an",   32'(an),   32'hF);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        scan_check("midrst_disp", {4{BLANK}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
